// File: rtl/spram_burst_master.sv
// spram_burst_master: burst initiator for the single-port RAM.
// Wrapping read/write bursts; read data returns through a 4-entry FIFO.
module spram_burst_master #(
  parameter int depth   = 64,
  parameter int width   = 8,
  parameter int max_len = 16,
  localparam int aw = $clog2(depth),
  localparam int lw = $clog2(max_len)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [aw-1:0]    cmd_addr,
  input  logic [lw-1:0]    cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [width-1:0] wdata,
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [width-1:0] rdata,
  output logic             done,
  output logic             ram_wr_en,
  output logic [aw-1:0]    ram_addr,
  output logic [width-1:0] ram_din,
  input  logic [width-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, DRAIN
  } state_t;

  state_t           state;
  logic [aw-1:0]    cur_addr;
  logic [lw-1:0]    beats_left;
  logic             v1;
  logic [width-1:0] fifo_mem [4];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [2:0]       fifo_count;
  logic             issue;
  logic             push;
  logic             pop;
  logic             last;
  logic [aw-1:0]    next_addr;

  assign next_addr = (cur_addr == aw'(depth - 1))
                   ? '0 : cur_addr + aw'(1);
  assign last = (beats_left == '0);

  // Credit: in-flight read plus this one must still fit in the FIFO
  assign issue = (state == READ) &&
    (({1'b0, fifo_count} + {3'b000, v1}) <= 4'd3);
  assign push = v1;
  assign pop  = rdata_valid && rdata_ready;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign ram_wr_en   = wdata_ready && wdata_valid;
  assign ram_din     = wdata_ready ? wdata : '0;
  assign ram_addr    = cur_addr;
  assign rdata_valid = (fifo_count != 3'd0);
  assign rdata       = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      v1         <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      v1   <= issue;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr   <= cmd_addr;
            beats_left <= cmd_len;
            state      <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wdata_valid) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - lw'(1);
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - lw'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!v1 && (fifo_count == 3'd0 ||
              (fifo_count == 3'd1 && pop))) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_dout;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == 3'd4));
`endif

endmodule

// File: tb/tb_spram_burst_master.sv
// tb_spram_burst_master: directed + randomized bursts checked against
// a reference memory image and per-burst expected read queues.
`timescale 1ns/1ps
module tb_spram_burst_master;
  localparam int DEPTH = 64;
  localparam int MAXL  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [5:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic [7:0] wdata = '0;
  logic       rdata_valid;
  logic       rdata_ready = 1'b0;
  logic [7:0] rdata;
  logic       done;
  logic       ram_wr_en;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] ram [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] wbuf [MAXL];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spram_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata(rdata), .done(done),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with 1-cycle synchronous read
  always @(posedge clk) begin
    ram_dout <= ram[ram_addr];
    if (ram_wr_en) ram[ram_addr] = ram_din;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_done", done, 0);
    check("rst_ram_wr_en", ram_wr_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] a,
                          input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    #1 check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] a, input logic [3:0] l,
                             input int mode, input bit intrude);
    logic [5:0] ea;
    int beat;
    int cyc;
    logic v;
    ea = a;
    beat = 0;
    cyc = 0;
    send_cmd(1'b1, a, l);
    while (beat <= int'(l) && cyc < 200) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      wdata_valid = v;
      wdata = wbuf[beat];
      if (intrude) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 6'($urandom);
        cmd_len   = 4'($urandom);
      end
      #1;
      check("wr_en", ram_wr_en, v);
      check("wr_wdata_ready", wdata_ready, 1);
      check("wr_done_early", done, 0);
      if (intrude) check("wr_cmd_ignored", cmd_ready, 0);
      if (v) begin
        check("wr_addr", ram_addr, ea);
        check("wr_din", ram_din, wbuf[beat]);
      end
      @(posedge clk);
      if (v) begin
        ref_mem[ea] = wbuf[beat];
        ea = ea + 6'd1;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    wdata_valid = 1'b0;
    check("wr_timeout", 32'(cyc < 200), 1);
    #1;
    check("wr_done", done, 1);
    check("wr_cmd_ready_after", cmd_ready, 1);
    @(negedge clk);
    #1 check("wr_done_pulse", done, 0);
  endtask

  task automatic read_burst(input logic [5:0] a, input logic [3:0] l,
                            input int mode);
    logic [7:0] expq[$];
    logic [5:0] stop_addr;
    int got;
    int cyc;
    int n;
    logic r;
    got = 0;
    cyc = 1;
    for (int i = 0; i <= int'(l); i++)
      expq.push_back(ref_mem[(int'(a) + i) % DEPTH]);
    n = (int'(l) + 1 < 4) ? int'(l) + 1 : 4;
    stop_addr = 6'(int'(a) + n);
    send_cmd(1'b0, a, l);
    while (got <= int'(l) && cyc < 400) begin
      case (mode)
        0: r = 1'b1;
        1: r = (cyc > 10);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rdata_ready = r;
      #1;
      check("rd_wr_en", ram_wr_en, 0);
      check("rd_done_early", done, 0);
      if (mode == 1 && cyc == 10) begin
        check("rd_issue_stop", ram_addr, stop_addr);
        check("rd_stall_valid", rdata_valid, 1);
      end
      if (mode == 0 && cyc < 3)
        check("rd_latency", rdata_valid, 0);
      if (rdata_valid && r) begin
        check("rd_data", rdata, expq[got]);
        if (mode == 0) check("rd_cycle", cyc, 3 + got);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    rdata_ready = 1'b0;
    check("rd_count", got, int'(l) + 1);
    #1;
    check("rd_done", done, 1);
    check("rd_cmd_ready_after", cmd_ready, 1);
    @(negedge clk);
    #1 check("rd_done_pulse", done, 0);
  endtask

  initial begin
    logic [5:0] a;
    logic [3:0] l;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Wrapping write then read across 0x3F -> 0x00
    wbuf[0] = 8'hA0; wbuf[1] = 8'hA1;
    wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
    write_burst(6'h3E, 4'd3, 0, 1'b0);
    check("ram_3e", ram[6'h3E], 8'hA0);
    check("ram_3f", ram[6'h3F], 8'hA1);
    check("ram_00", ram[6'h00], 8'hA2);
    check("ram_01", ram[6'h01], 8'hA3);
    read_burst(6'h3E, 4'd3, 0);

    // Full-length burst read with consumer stalled
    for (int i = 0; i < MAXL; i++) wbuf[i] = 8'($urandom);
    write_burst(6'h20, 4'd15, 0, 1'b0);
    read_burst(6'h20, 4'd15, 1);

    // Toggling write data with commands offered mid-burst
    for (int i = 0; i < MAXL; i++) wbuf[i] = 8'($urandom);
    write_burst(6'h05, 4'd3, 1, 1'b1);
    read_burst(6'h05, 4'd3, 0);

    // Reset after two beats of a four-beat write
    for (int i = 0; i < MAXL; i++) wbuf[i] = 8'($urandom);
    send_cmd(1'b1, 6'h10, 4'd3);
    for (int b = 0; b < 2; b++) begin
      wdata_valid = 1'b1;
      wdata = wbuf[b];
      @(posedge clk);
      ref_mem[16 + b] = wbuf[b];
      @(negedge clk);
    end
    wdata_valid = 1'b1;
    wdata = wbuf[2];
    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    wdata_valid = 1'b0;
    rst_n = 1'b1;
    read_burst(6'h10, 4'd3, 0);

    // Randomized mix of bursts
    for (int it = 0; it < 40; it++) begin
      a = 6'($urandom);
      l = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < MAXL; i++) wbuf[i] = 8'($urandom);
        write_burst(a, l, 2, 1'($urandom_range(0, 1)));
      end else begin
        read_burst(a, l, int'($urandom_range(0, 2)));
      end
    end

    for (int i = 0; i < DEPTH; i++)
      check("ram_final", ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
